multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
Moore/Mealy control FSM that sequences the multicycle CPU datapath through the IF, ID, EXE, MEM and WB states defined by state_t. Decodes the registered instruction's opcode_t/func_t fields and drives every datapath strobe and mux select. Sits beside the datapath top and handshakes with the unified instruction/data memory port.

Parameters:
OPCODE_WIDTH, 6, opcode field width (from instruction_set_pkg)
FUNC_WIDTH, 6, func field width (from instruction_set_pkg)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  6  IR[31:26], stable from the end of IF
func  in  6  IR[5:0]
zero  in  1  ALU zero flag, valid in EXE
mem_ready  in  1  memory access completes this cycle
mem_read  out  1  memory read request
mem_write  out  1  memory write request
iord  out  1  0=PC address, 1=ALUOut address
ir_write  out  1  load IR
pc_write  out  1  load PC (already qualified for branches)
pc_src  out  2  0=ALU result, 1=ALUOut (branch target), 2=jump target, 3=register rs
alu_src_a  out  1  0=PC, 1=rs
alu_src_b  out  2  0=rt, 1=const 4, 2=imm per imm_sel, 3=imm<<2
alu_op  out  4  alu_op_t
imm_sel  out  2  imm_sel_t: SEXT, ZEXT, UPPER, LOWER
reg_write  out  1  register-file write enable
reg_dst  out  2  0=rt, 1=rd, 2=r31 (link)
wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC (link)
state  out  3  current state_t
illegal  out  1  one-cycle pulse on an undecodable opcode/func

Behaviour:
- Reset: while rst_n=0 at a clk edge, state<=IF. While rst_n is low, all strobes (mem_read, mem_write, ir_write, pc_write, reg_write, illegal) are 0. Selects are 0 and alu_op=ALU_ADD. Reset mid-access abandons the access; no write strobe is asserted in the cycle after reset.
- Outputs are combinational from state plus opcode/func. There are no registered outputs except state.
- IF: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0. On mem_ready=1: ir_write=1, pc_write=1, go to ID. Otherwise hold in IF with ir_write=0 and pc_write=0.
- ID: alu_src_a=0, alu_src_b=3, alu_op=ADD (precomputes the branch target into ALUOut). Legal opcode goes to EXE. Illegal opcode, or RTYPE with an undefined func: pulse illegal, go to IF.
- EXE, per opcode:
  - RTYPE (non-JR): alu_src_a=1, alu_src_b=0, alu_op from func. Go to WB.
  - RTYPE with F_JR, or JR: pc_src=3, pc_write=1. Go to IF.
  - ADDI/SUBI: imm_sel=SEXT. ANDI/ORI/XORI: imm_sel=ZEXT. All use alu_src_b=2 and go to WB.
  - LUI: imm_sel=UPPER, alu_op=PASSB. LLI: imm_sel=LOWER, alu_op=PASSB. Both go to WB.
  - LW/SW: alu_src_a=1, alu_src_b=2, SEXT, ADD. Go to MEM.
  - BEQ/BNE: alu_op=SUB, pc_src=1. pc_write=zero for BEQ, pc_write=~zero for BNE. Go to IF.
  - JMP: pc_src=2, pc_write=1. Go to IF.
  - JAL: pc_src=2, pc_write=1, go to WB. The link value is the PC already incremented in IF.
- MEM: iord=1.
  - LW: mem_read=1. Go to WB on mem_ready, else hold.
  - SW: mem_write=1. Go to IF on mem_ready, else hold. mem_write stays asserted for every wait cycle.
- WB: reg_write=1, then go to IF.
  - RTYPE: reg_dst=1, wb_sel=0. Immediates/LUI/LLI: reg_dst=0, wb_sel=0.
  - LW: reg_dst=0, wb_sel=1. JAL: reg_dst=2, wb_sel=2.
- Latencies (cycles, zero wait):
  - Branch, jump, JR: 3.
  - R-type, immediate, LUI/LLI, JAL: 4.
  - SW: 4.
  - LW: 5.
  - Each wait cycle adds 1.
- Invalid state encodings (3'b101 to 3'b111) go to IF on the next edge with all strobes 0.

Optional Feature:
MEM_HANDSHAKE_EN.
- Defined: IF and MEM wait on mem_ready as described above.
- Undefined: mem_ready is ignored and treated as 1. Every memory state lasts exactly one cycle. The port remains present.

Decomposition:
- Add to instruction_set_pkg:
  - alu_op_t (4-bit: ALU_ADD, SUB, AND, OR, XOR, SLL, SRL, SLA, SRA, PASSB).
  - imm_sel_t.
  - pc_src_t.
  - Constants for the alu_src_b/reg_dst/wb_sel encodings.
- One sub-module, alu_decoder: a combinational map from (state, opcode, func) to alu_op and imm_sel. The FSM and strobe logic stay in the top.

Test Plan:
1. Reset, then ADD (RTYPE, func=F_ADD) with mem_ready=1 → state sequence IF,ID,EXE,WB,IF. alu_op=ADD in EXE. reg_write=1 with reg_dst=1 in WB only.
2. BEQ with zero=1, then BEQ with zero=0 → EXE pc_write=1, pc_src=1 for the first and pc_write=0 for the second. Both return to IF after 3 cycles. Repeat for BNE with inverted results.
3. LW with mem_ready low for 2 cycles in MEM → mem_read=1 and iord=1 held 3 cycles. WB reg_write=1, wb_sel=1. Total 7 cycles.
4. SW, then rst_n=0 during the MEM wait → mem_write drops the cycle after the reset edge. State=IF and all strobes 0.
5. JAL → EXE pc_write=1, pc_src=2. WB reg_write=1, reg_dst=2, wb_sel=2. Also cover the JR and RTYPE/F_JR paths (pc_src=3).
6. opcode=6'b111111, and RTYPE with func=6'b010101 → illegal pulses for one cycle in ID. No reg_write or pc_write. Returns to IF. With MEM_HANDSHAKE_EN undefined, an LW holding mem_ready=0 still completes in 5 cycles.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_pkg
// Description : Instruction-set definitions for the multicycle CPU control path.
//               Holds the FSM states, opcode/func encodings, ALU operations,
//               immediate modes, and datapath select encodings. Also holds
//               small decode helpers that the control unit and ALU decoder
//               share.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_unit_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int FUNC_WIDTH   = 6;

  typedef enum logic [2:0] {
    IF  = 3'd0,
    ID  = 3'd1,
    EXE = 3'd2,
    MEM = 3'd3,
    WB  = 3'd4
  } state_t;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    RTYPE = 6'h00,
    ADDI  = 6'h01,
    SUBI  = 6'h02,
    ANDI  = 6'h03,
    ORI   = 6'h04,
    XORI  = 6'h05,
    LUI   = 6'h06,
    LLI   = 6'h07,
    LW    = 6'h08,
    SW    = 6'h09,
    BEQ   = 6'h0A,
    BNE   = 6'h0B,
    JMP   = 6'h0C,
    JAL   = 6'h0D,
    JR    = 6'h0E
  } opcode_t;

  typedef enum logic [FUNC_WIDTH-1:0] {
    F_ADD = 6'h00,
    F_SUB = 6'h01,
    F_AND = 6'h02,
    F_OR  = 6'h03,
    F_XOR = 6'h04,
    F_SLL = 6'h05,
    F_SRL = 6'h06,
    F_SLA = 6'h07,
    F_SRA = 6'h08,
    F_JR  = 6'h09
  } func_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SLA   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_PASSB = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_SEXT  = 2'd0,
    IMM_ZEXT  = 2'd1,
    IMM_UPPER = 2'd2,
    IMM_LOWER = 2'd3
  } imm_sel_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'd0,  // PC + 4 computed in IF
    PC_ALUOUT = 2'd1,  // branch target precomputed in ID
    PC_JUMP   = 2'd2,
    PC_RS     = 2'd3
  } pc_src_t;

  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_RS      = 1'b1;

  localparam logic [1:0] SRC_B_RT      = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

  localparam logic [1:0] REG_DST_RT    = 2'd0;
  localparam logic [1:0] REG_DST_RD    = 2'd1;
  localparam logic [1:0] REG_DST_R31   = 2'd2;

  localparam logic [1:0] WB_ALUOUT     = 2'd0;
  localparam logic [1:0] WB_MDR        = 2'd1;
  localparam logic [1:0] WB_PC         = 2'd2;

  // True for every func code the R-type datapath understands (JR included).
  function automatic logic func_defined(input logic [FUNC_WIDTH-1:0] fn);
    case (fn)
      F_ADD, F_SUB, F_AND, F_OR, F_XOR,
      F_SLL, F_SRL, F_SLA, F_SRA, F_JR: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

  // An instruction is decodable when its opcode is known and, for R-type,
  // its func is known as well.
  function automatic logic insn_legal(input logic [OPCODE_WIDTH-1:0] op,
                                      input logic [FUNC_WIDTH-1:0]   fn);
    case (op)
      RTYPE:                        return func_defined(fn);
      ADDI, SUBI, ANDI, ORI, XORI,
      LUI, LLI, LW, SW, BEQ, BNE,
      JMP, JAL, JR:                 return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic alu_op_t func_alu_op(input logic [FUNC_WIDTH-1:0] fn);
    case (fn)
      F_SUB:   return ALU_SUB;
      F_AND:   return ALU_AND;
      F_OR:    return ALU_OR;
      F_XOR:   return ALU_XOR;
      F_SLL:   return ALU_SLL;
      F_SRL:   return ALU_SRL;
      F_SLA:   return ALU_SLA;
      F_SRA:   return ALU_SRA;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control_unit_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_alu_decoder
// Description : Combinational map from (state, opcode, func) to the ALU
//               operation and immediate-extension mode. Only EXE selects
//               anything other than ADD / sign-extend; IF and ID use the ALU
//               as an adder for PC+4 and the branch target.
// Ports       : state   in  3  current FSM state
//               opcode  in  6  instruction opcode
//               func    in  6  R-type function code
//               alu_op  out 4  ALU operation
//               imm_sel out 2  immediate extension mode
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit_alu_decoder
  import multicycle_control_unit_pkg::*;
(
  input  logic [2:0]              state,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNC_WIDTH-1:0]   func,
  output alu_op_t                 alu_op,
  output imm_sel_t                imm_sel
);

  always_comb begin
    alu_op  = ALU_ADD;
    imm_sel = IMM_SEXT;
    if (state == EXE) begin
      case (opcode)
        RTYPE:    alu_op = func_alu_op(func);
        SUBI:     alu_op = ALU_SUB;
        ANDI: begin
          alu_op  = ALU_AND;
          imm_sel = IMM_ZEXT;
        end
        ORI: begin
          alu_op  = ALU_OR;
          imm_sel = IMM_ZEXT;
        end
        XORI: begin
          alu_op  = ALU_XOR;
          imm_sel = IMM_ZEXT;
        end
        LUI: begin
          alu_op  = ALU_PASSB;
          imm_sel = IMM_UPPER;
        end
        LLI: begin
          alu_op  = ALU_PASSB;
          imm_sel = IMM_LOWER;
        end
        BEQ, BNE: alu_op = ALU_SUB;
        default:  ;  // ADDI/LW/SW and jumps: ADD with sign-extend
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Control FSM for the multicycle CPU. Walks IF/ID/EXE/MEM/WB,
//               decodes the IR opcode/func and drives every datapath strobe
//               and mux select combinationally from the current state. Only
//               the state itself is registered.
// Config      : MEM_HANDSHAKE_EN - when defined, IF and MEM wait for
//               mem_ready; when undefined, every memory state lasts one cycle
//               and mem_ready is ignored.
// Ports       : clk, rst_n (sync, active low)
//               opcode, func, zero, mem_ready          - inputs
//               mem_read, mem_write, iord, ir_write,
//               pc_write, pc_src, alu_src_a, alu_src_b,
//               alu_op, imm_sel, reg_write, reg_dst,
//               wb_sel                                 - datapath controls
//               state                                  - current state
//               illegal                                - undecodable insn pulse
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNC_WIDTH-1:0]   func,
  input  logic                    zero,
  input  logic                    mem_ready,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic                    iord,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic [1:0]              pc_src,
  output logic                    alu_src_a,
  output logic [1:0]              alu_src_b,
  output logic [3:0]              alu_op,
  output logic [1:0]              imm_sel,
  output logic                    reg_write,
  output logic [1:0]              reg_dst,
  output logic [1:0]              wb_sel,
  output logic [2:0]              state,
  output logic                    illegal
);

  // Kept as raw bits so the unused encodings 5..7 can be recovered from.
  logic [2:0] cur_state;
  logic [2:0] nxt_state;
  logic       mem_done;
  alu_op_t    dec_alu_op;
  imm_sel_t   dec_imm_sel;

`ifdef MEM_HANDSHAKE_EN
  assign mem_done = mem_ready;
`else
  assign mem_done = 1'b1;
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
`endif

  multicycle_control_unit_alu_decoder u_alu_decoder (
    .state   (cur_state),
    .opcode  (opcode),
    .func    (func),
    .alu_op  (dec_alu_op),
    .imm_sel (dec_imm_sel)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= IF;
    else        cur_state <= nxt_state;
  end

  assign state = cur_state;

  always_comb begin
    nxt_state = IF;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = PC_ALU;
    alu_src_a = SRC_A_PC;
    alu_src_b = SRC_B_RT;
    alu_op    = dec_alu_op;
    imm_sel   = dec_imm_sel;
    reg_write = 1'b0;
    reg_dst   = REG_DST_RT;
    wb_sel    = WB_ALUOUT;
    illegal   = 1'b0;

    case (cur_state)
      IF: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        if (mem_done) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          nxt_state = ID;
        end else begin
          nxt_state = IF;
        end
      end

      ID: begin
        // ALUOut <= PC + (imm << 2): branch target ready for EXE.
        alu_src_b = SRC_B_IMM_SH2;
        if (insn_legal(opcode, func)) begin
          nxt_state = EXE;
        end else begin
          illegal   = 1'b1;
          nxt_state = IF;
        end
      end

      EXE: begin
        case (opcode)
          RTYPE: begin
            if (func == F_JR) begin
              pc_src    = PC_RS;
              pc_write  = 1'b1;
              nxt_state = IF;
            end else begin
              alu_src_a = SRC_A_RS;
              alu_src_b = SRC_B_RT;
              nxt_state = WB;
            end
          end
          JR: begin
            pc_src    = PC_RS;
            pc_write  = 1'b1;
            nxt_state = IF;
          end
          ADDI, SUBI, ANDI, ORI, XORI, LUI, LLI: begin
            alu_src_a = SRC_A_RS;
            alu_src_b = SRC_B_IMM;
            nxt_state = WB;
          end
          LW, SW: begin
            alu_src_a = SRC_A_RS;
            alu_src_b = SRC_B_IMM;
            nxt_state = MEM;
          end
          BEQ, BNE: begin
            // ALU compares rs-rt; the PC load is qualified here so the
            // datapath needs no branch logic of its own.
            alu_src_a = SRC_A_RS;
            alu_src_b = SRC_B_RT;
            pc_src    = PC_ALUOUT;
            pc_write  = (opcode == BNE) ? ~zero : zero;
            nxt_state = IF;
          end
          JMP: begin
            pc_src    = PC_JUMP;
            pc_write  = 1'b1;
            nxt_state = IF;
          end
          JAL: begin
            pc_src    = PC_JUMP;
            pc_write  = 1'b1;
            nxt_state = WB;
          end
          default: nxt_state = IF;
        endcase
      end

      MEM: begin
        iord = 1'b1;
        if (opcode == LW) begin
          mem_read  = 1'b1;
          nxt_state = mem_done ? WB : MEM;
        end else if (opcode == SW) begin
          mem_write = 1'b1;
          nxt_state = mem_done ? IF : MEM;
        end else begin
          nxt_state = IF;
        end
      end

      WB: begin
        reg_write = 1'b1;
        case (opcode)
          RTYPE:   reg_dst = REG_DST_RD;
          LW:      wb_sel  = WB_MDR;
          JAL: begin
            reg_dst = REG_DST_R31;
            wb_sel  = WB_PC;
          end
          default: ;
        endcase
        nxt_state = IF;
      end

      default: begin
        // Unused encodings: all strobes stay low, return to fetch.
        alu_op    = ALU_ADD;
        imm_sel   = IMM_SEXT;
        nxt_state = IF;
      end
    endcase

    // Reset abandons any access in flight: nothing may strobe while low.
    if (!rst_n) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      iord      = 1'b0;
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      pc_src    = PC_ALU;
      alu_src_a = SRC_A_PC;
      alu_src_b = SRC_B_RT;
      alu_op    = ALU_ADD;
      imm_sel   = IMM_SEXT;
      reg_write = 1'b0;
      reg_dst   = REG_DST_RT;
      wb_sel    = WB_ALUOUT;
      illegal   = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Self-checking bench for multicycle_control_unit. Each
//               instruction is expanded into its expected route of states,
//               an output table derived from the ISA behaviour gives the
//               expected controls for every cycle, and a few literal values
//               pin the expected route lengths and key strobes.
// Config      : follows MEM_HANDSHAKE_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam logic [5:0] OP_R    = 6'h00, OP_ADDI = 6'h01, OP_SUBI = 6'h02,
                         OP_ANDI = 6'h03, OP_ORI  = 6'h04, OP_XORI = 6'h05,
                         OP_LUI  = 6'h06, OP_LLI  = 6'h07, OP_LW   = 6'h08,
                         OP_SW   = 6'h09, OP_BEQ  = 6'h0A, OP_BNE  = 6'h0B,
                         OP_JMP  = 6'h0C, OP_JAL  = 6'h0D, OP_JR   = 6'h0E;
  localparam logic [5:0] FN_ADD = 6'h00, FN_SUB = 6'h01, FN_JR = 6'h09;
  localparam int P_IF = 0, P_ID = 1, P_EXE = 2, P_MEM = 3, P_WB = 4;
`ifdef MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, iord, ir_write, pc_write, alu_src_a;
  logic       reg_write, illegal;
  logic [1:0] pc_src, alu_src_b, imm_sel, reg_dst, wb_sel;
  logic [3:0] alu_op;
  logic [2:0] state;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write),
    .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_sel(imm_sel), .reg_write(reg_write), .reg_dst(reg_dst),
    .wb_sel(wb_sel), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] imm_sel;
    logic       reg_write;
    logic [1:0] reg_dst, wb_sel;
    logic [2:0] state;
    logic       illegal;
  } outs_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  bit    exp_valid = 1'b0;
  int    exp_ph  = P_IF;
  outs_t trace[$];
  int    route_ph[$];
  bit    route_rdy[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic outs_t dut_outs();
    outs_t o;
    o = '{mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
          alu_src_b, alu_op, imm_sel, reg_write, reg_dst, wb_sel, state, illegal};
    return o;
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    return (op <= OP_JR) && (op != OP_R || fn <= FN_JR);
  endfunction

  // Expected controls for one cycle, straight from the ISA behaviour table.
  function automatic outs_t exp_out(input int ph, input logic [5:0] op,
                                    input logic [5:0] fn, input logic z,
                                    input logic rdy, input logic rn);
    outs_t o;
    bit    ok, jr;
    o = '0;
    o.state = 3'(ph);
    if (!rn) return o;
    ok = HS ? rdy : 1'b1;
    jr = (op == OP_JR) || (op == OP_R && fn == FN_JR);
    case (ph)
      P_IF: begin
        o.mem_read = 1; o.alu_src_b = 1; o.ir_write = ok; o.pc_write = ok;
      end
      P_ID: begin
        o.alu_src_b = 3; o.illegal = !legal(op, fn);
      end
      P_EXE: begin
        if (jr) begin
          o.pc_src = 3; o.pc_write = 1;
        end else if (op == OP_R) begin
          // func codes 0..8 share their numbering with the ALU codes
          o.alu_src_a = 1; o.alu_op = (fn <= 6'd8) ? fn[3:0] : 4'd0;
        end else if (op >= OP_ADDI && op <= OP_XORI) begin
          o.alu_src_a = 1; o.alu_src_b = 2;
          o.alu_op = 4'(op - 6'd1);
          o.imm_sel = (op >= OP_ANDI) ? 2'd1 : 2'd0;
        end else if (op == OP_LUI || op == OP_LLI) begin
          o.alu_src_a = 1; o.alu_src_b = 2; o.alu_op = 4'd9;
          o.imm_sel = (op == OP_LUI) ? 2'd2 : 2'd3;
        end else if (op == OP_LW || op == OP_SW) begin
          o.alu_src_a = 1; o.alu_src_b = 2;
        end else if (op == OP_BEQ || op == OP_BNE) begin
          o.alu_src_a = 1; o.alu_op = 4'd1; o.pc_src = 1;
          o.pc_write = (op == OP_BEQ) ? z : !z;
        end else begin
          o.pc_src = 2; o.pc_write = 1;
        end
      end
      P_MEM: begin
        o.iord = 1; o.mem_read = (op == OP_LW); o.mem_write = (op == OP_SW);
      end
      P_WB: begin
        o.reg_write = 1;
        o.reg_dst = (op == OP_R) ? 2'd1 : (op == OP_JAL) ? 2'd2 : 2'd0;
        o.wb_sel  = (op == OP_LW) ? 2'd1 : (op == OP_JAL) ? 2'd2 : 2'd0;
      end
      default: ;
    endcase
    return o;
  endfunction

  // Single compare process: every cycle the driver marks as meaningful.
  always @(negedge clk) begin
    outs_t e, a;
    cyc++;
    if (exp_valid) begin
      e = exp_out(exp_ph, opcode, func, zero, mem_ready, rst_n);
      a = dut_outs();
      chk($sformatf("c%0d.state", cyc), a.state, e.state);
      chk($sformatf("c%0d.mem_read", cyc), a.mem_read, e.mem_read);
      chk($sformatf("c%0d.mem_write", cyc), a.mem_write, e.mem_write);
      chk($sformatf("c%0d.iord", cyc), a.iord, e.iord);
      chk($sformatf("c%0d.ir_write", cyc), a.ir_write, e.ir_write);
      chk($sformatf("c%0d.pc_write", cyc), a.pc_write, e.pc_write);
      chk($sformatf("c%0d.pc_src", cyc), a.pc_src, e.pc_src);
      chk($sformatf("c%0d.alu_src_a", cyc), a.alu_src_a, e.alu_src_a);
      chk($sformatf("c%0d.alu_src_b", cyc), a.alu_src_b, e.alu_src_b);
      chk($sformatf("c%0d.alu_op", cyc), a.alu_op, e.alu_op);
      chk($sformatf("c%0d.imm_sel", cyc), a.imm_sel, e.imm_sel);
      chk($sformatf("c%0d.reg_write", cyc), a.reg_write, e.reg_write);
      chk($sformatf("c%0d.reg_dst", cyc), a.reg_dst, e.reg_dst);
      chk($sformatf("c%0d.wb_sel", cyc), a.wb_sel, e.wb_sel);
      chk($sformatf("c%0d.illegal", cyc), a.illegal, e.illegal);
    end
  end

  // One clock of stimulus; inputs change just after the rising edge.
  task automatic step(input int ph, input bit rdy, input bit rn);
    mem_ready = rdy;
    rst_n     = rn;
    exp_ph    = ph;
    exp_valid = 1'b1;
    @(negedge clk);
    #1;
    trace.push_back(dut_outs());
    @(posedge clk);
    #1;
  endtask

  task automatic add_mem_phase(input int ph, input int waits);
    if (HS) begin
      for (int i = 0; i < waits; i++) begin
        route_ph.push_back(ph); route_rdy.push_back(1'b0);
      end
      route_ph.push_back(ph); route_rdy.push_back(1'b1);
    end else begin
      route_ph.push_back(ph); route_rdy.push_back(waits == 0);
    end
  endtask

  task automatic build_route(input logic [5:0] op, input logic [5:0] fn,
                             input int if_w, input int mem_w);
    route_ph.delete();
    route_rdy.delete();
    add_mem_phase(P_IF, if_w);
    route_ph.push_back(P_ID); route_rdy.push_back(1'b0);
    if (!legal(op, fn)) return;
    route_ph.push_back(P_EXE); route_rdy.push_back(1'b0);
    if (op == OP_LW) begin
      add_mem_phase(P_MEM, mem_w);
      route_ph.push_back(P_WB); route_rdy.push_back(1'b0);
    end else if (op == OP_SW) begin
      add_mem_phase(P_MEM, mem_w);
    end else if (op == OP_R && fn != FN_JR || op == OP_JAL ||
                 (op >= OP_ADDI && op <= OP_LLI)) begin
      route_ph.push_back(P_WB); route_rdy.push_back(1'b0);
    end
  endtask

  task automatic run_instr(input string nm, input logic [5:0] op,
                           input logic [5:0] fn, input logic z,
                           input int if_w, input int mem_w, input int exp_len);
    build_route(op, fn, if_w, mem_w);
    chk({nm, ".latency"}, route_ph.size(), exp_len);
    trace.delete();
    opcode = op; func = fn; zero = z;
    for (int i = 0; i < route_ph.size(); i++) step(route_ph[i], route_rdy[i], 1'b1);
  endtask

  logic [5:0] imm_ops [7] = '{OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LLI};
  int         imm_alu [7] = '{0, 1, 2, 3, 4, 9, 9};
  int         imm_ext [7] = '{0, 0, 1, 1, 1, 2, 3};

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    // Held in reset: IF with nothing asserted.
    trace.delete();
    step(P_IF, 1'b1, 1'b0);
    chk("reset.state", trace[0].state, 0);
    chk("reset.mem_read", trace[0].mem_read, 0);

    run_instr("add", OP_R, FN_ADD, 1'b0, 0, 0, 4);
    chk("add.exe_state", trace[2].state, 2);
    chk("add.wb_state", trace[3].state, 4);
    chk("add.exe_reg_write", trace[2].reg_write, 0);
    chk("add.wb_reg_dst", trace[3].reg_dst, 1);
    for (int f = 1; f <= 8; f++) begin
      run_instr($sformatf("rfn%0d", f), OP_R, 6'(f), 1'b1, 0, 0, 4);
      chk($sformatf("rfn%0d.alu_op", f), trace[2].alu_op, f);
    end

    run_instr("beq_t", OP_BEQ, 6'h15, 1'b1, 0, 0, 3);
    chk("beq_t.pc_write", trace[2].pc_write, 1);
    chk("beq_t.pc_src", trace[2].pc_src, 1);
    run_instr("beq_n", OP_BEQ, 6'h15, 1'b0, 0, 0, 3);
    chk("beq_n.pc_write", trace[2].pc_write, 0);
    run_instr("bne_t", OP_BNE, 6'h00, 1'b0, 0, 0, 3);
    chk("bne_t.pc_write", trace[2].pc_write, 1);
    run_instr("bne_n", OP_BNE, 6'h00, 1'b1, 0, 0, 3);
    chk("bne_n.pc_write", trace[2].pc_write, 0);

    run_instr("lw_wait", OP_LW, 6'h00, 1'b0, 0, 2, HS ? 7 : 5);
    n = 0;
    foreach (trace[i]) if (trace[i].mem_read && trace[i].iord) n++;
    chk("lw_wait.mem_cycles", n, HS ? 3 : 1);
    chk("lw_wait.wb_sel", trace[trace.size()-1].wb_sel, 1);
    run_instr("lw", OP_LW, 6'h00, 1'b0, 0, 0, 5);
    run_instr("addi_ifwait", OP_ADDI, 6'h00, 1'b0, 1, 0, HS ? 5 : 4);
    run_instr("sw", OP_SW, 6'h00, 1'b0, 0, 1, HS ? 5 : 4);
    chk("sw.mem_write_first", trace[3].mem_write, 1);

    // SW aborted by reset while in MEM.
    trace.delete();
    opcode = OP_SW; func = 6'h00; zero = 1'b0;
    step(P_IF, 1'b1, 1'b1);
    step(P_ID, 1'b0, 1'b1);
    step(P_EXE, 1'b0, 1'b1);
    if (HS) step(P_MEM, 1'b0, 1'b1);
    step(P_MEM, 1'b0, 1'b0);
    step(P_IF, 1'b1, 1'b0);
    n = trace.size();
    chk("sw_rst.pre_mem_write", trace[n-3].mem_write, HS ? 1 : 0);
    chk("sw_rst.mem_write_in_rst", trace[n-2].mem_write, 0);
    chk("sw_rst.state_after", trace[n-1].state, 0);
    chk("sw_rst.mem_read_after", trace[n-1].mem_read, 0);

    run_instr("jal", OP_JAL, 6'h00, 1'b0, 0, 0, 4);
    chk("jal.pc_src", trace[2].pc_src, 2);
    chk("jal.reg_dst", trace[3].reg_dst, 2);
    chk("jal.wb_sel", trace[3].wb_sel, 2);
    run_instr("jr", OP_JR, 6'h00, 1'b0, 0, 0, 3);
    chk("jr.pc_src", trace[2].pc_src, 3);
    run_instr("rjr", OP_R, FN_JR, 1'b0, 0, 0, 3);
    chk("rjr.pc_src", trace[2].pc_src, 3);
    chk("rjr.pc_write", trace[2].pc_write, 1);
    run_instr("jmp", OP_JMP, 6'h00, 1'b0, 0, 0, 3);

    for (int i = 0; i < 7; i++) begin
      run_instr($sformatf("imm%0d", i), imm_ops[i], 6'h15, 1'b0, 0, 0, 4);
      chk($sformatf("imm%0d.alu_op", i), trace[2].alu_op, imm_alu[i]);
      chk($sformatf("imm%0d.imm_sel", i), trace[2].imm_sel, imm_ext[i]);
    end

    run_instr("bad_op", 6'h3F, 6'h00, 1'b0, 0, 0, 2);
    chk("bad_op.illegal", trace[1].illegal, 1);
    chk("bad_op.if_illegal", trace[0].illegal, 0);
    run_instr("bad_fn", OP_R, 6'h15, 1'b0, 0, 0, 2);
    chk("bad_fn.illegal", trace[1].illegal, 1);
    run_instr("sub_after", OP_R, FN_SUB, 1'b0, 0, 0, 4);
    chk("sub_after.illegal", trace[1].illegal, 0);
    // mem_ready held low on every memory cycle
    run_instr("lw_noready", OP_LW, 6'h00, 1'b0, 1, 1, HS ? 7 : 5);

    trace.delete();
    opcode = OP_R; func = FN_ADD;
    step(P_IF, 1'b1, 1'b1);
    exp_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
